background_rom_arbiter: RTL and testbench
=========================================

// Module: background_rom_arbiter
// PURPOSE
//  Shares the single-port, 1-cycle-latency background ROM (640x480, 4-bit palette index) between
//  the VGA pixel fetch and a game-logic query port (background index lookup at a point, e.g. the
//  bush/grass layer test for duck and dog depth). It converts (x,y) to a linear ROM address and
//  routes each returned word to its owner. Display has absolute priority during active video;
//  queries are served only while the display is idle (blanking).
// PARAMETERS
//  H_RES   640  horizontal pixels; address stride
//  V_RES   480  vertical lines
//  ADDR_W  19   ROM address width (must hold H_RES*V_RES-1)
//  DATA_W  4    palette index width
// PORTS
//  Clk          in   1       system clock; all logic on posedge
//  Reset        in   1       synchronous, active-low reset
//  DrawX        in   10      display pixel column
//  DrawY        in   10      display pixel row
//  disp_active  in   1       1 = display requests a pixel this cycle
//  disp_valid   out  1       disp_index valid
//  disp_index   out  DATA_W  background index for pixel issued 3 cycles earlier
//  q_req        in   1       query request; x,y held stable until accepted
//  q_x          in   10      query column
//  q_y          in   10      query row
//  q_ready      out  1       query accepted this cycle when q_req && q_ready
//  q_rvalid     out  1       1-cycle pulse: query result valid
//  q_rdata      out  DATA_W  query result
//  q_err        out  1       with q_rvalid: coordinate out of range, q_rdata = 0
//  rom_addr     out  ADDR_W  registered ROM read address
//  rom_data     in   DATA_W  ROM registered output (valid 1 cycle after rom_addr)
// BEHAVIOUR
//  - Reset (Reset==0 at posedge): rom_addr=0, disp_valid=0, disp_index=0, q_rvalid=0,
//    q_rdata=0, q_err=0, all tag-pipeline stages cleared. In-flight reads are discarded; no
//    result pulse follows a reset. q_ready is 0 while Reset==0.
//  - Issue select (comb, cycle t): disp_active -> display owns the slot; else q_req -> query.
//    q_ready = Reset && !disp_active. Display never stalls and is never delayed by queries.
//  - Address: addr = y*H_RES + x computed as (y<<9)+(y<<7)+x for H_RES=640, ADDR_W bits, no
//    overflow for in-range input. Registered into rom_addr at edge t+1. In range: x<H_RES && y<V_RES.
//  - Out-of-range or idle slot: rom_addr holds its previous value (no spurious address toggling);
//    tag marks the slot as "zero-fill".
//  - Tag pipeline: 3 stages of {valid, owner(DISP/QUERY), zero}; stage advances every cycle.
//  - Latency fixed at 3 cycles: request at t -> rom_addr at t+1 -> rom_data at t+2 -> outputs
//    registered at t+3. disp_valid/q_rvalid are single-cycle per request; back-to-back requests
//    produce back-to-back results (throughput 1/cycle).
//  - Zero-fill: display gets disp_index=0 with disp_valid=1; query gets q_rdata=0, q_err=1.
//  - disp_index holds last value when disp_valid=0; q_rdata holds last value when q_rvalid=0.
//  - disp_active rising mid-query: already accepted queries complete normally (pipelined);
//    unaccepted q_req waits (q_ready=0) until next blanking. No queue inside the block.
//  - Simultaneous disp_active and q_req: display wins, q_ready=0.
// STRUCTURE
//  - bg_rom_pkg: H_RES, V_RES, ADDR_W, DATA_W constants; typedef enum logic {OWN_DISP, OWN_QUERY}
//    owner_t; typedef struct packed {logic valid; owner_t owner; logic zero;} rd_tag_t.
//  - Sub-module bg_addr_calc: comb (x,y) -> {addr, in_range}; instantiated once after the mux.
//  - Top: issue mux, rom_addr register, 3-deep rd_tag_t shift, output registers.
// TESTING
//  - disp_active=1, (DrawX,DrawY)=(0,0) then (639,479) -> rom_addr 0 then 307199; disp_valid
//    pulses at t+3, t+4 with disp_index = ROM model contents.
//  - disp_active=0, q_req=1, (q_x,q_y)=(10,2) -> q_ready=1, rom_addr=1290 at t+1, q_rvalid=1,
//    q_err=0, q_rdata=mem[1290] at t+3.
//  - disp_active=1 and q_req=1 for 5 cycles, then disp_active=0 -> q_ready=0 for 5 cycles,
//    accepted on cycle 6; display results uninterrupted, all 5 disp_valid pulses present.
//  - Query (640,0) and display (5,480) -> no rom_addr change; q_rvalid=1, q_err=1, q_rdata=0;
//    disp_valid=1, disp_index=0.
//  - Issue 3 queries back-to-back, assert Reset=0 one cycle after the last -> all outputs 0 next
//    cycle, no q_rvalid pulses for any of the 3 after reset releases.

Source files
------------

// File: rtl/bg_rom_pkg.sv
// bg_rom_pkg: background ROM geometry and read-tag types shared by the arbiter
package bg_rom_pkg;
   localparam int H_RES  = 640;
   localparam int V_RES  = 480;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 4;
   typedef enum logic {OWN_DISP, OWN_QUERY} owner_t;
   typedef struct packed {
      logic   valid;
      owner_t owner;
      logic   zero;
   } rd_tag_t;
endpackage

// File: rtl/bg_addr_calc.sv
// bg_addr_calc: (x,y) to linear ROM address with range flag
module bg_addr_calc import bg_rom_pkg::*; (
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);
   // y*640 as two shifts keeps this adder-only
   assign addr     = (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
   assign in_range = (x < 10'(H_RES)) && (y < 10'(V_RES));
endmodule

// File: rtl/background_rom_arbiter.sv
// background_rom_arbiter: shares the background ROM between display fetch and game queries
module background_rom_arbiter import bg_rom_pkg::*; (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              disp_active,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_index,
   input  logic              q_req,
   input  logic [9:0]        q_x,
   input  logic [9:0]        q_y,
   output logic              q_ready,
   output logic              q_rvalid,
   output logic [DATA_W-1:0] q_rdata,
   output logic              q_err,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);
   logic              issue;
   logic              sel_q;
   logic [9:0]        x;
   logic [9:0]        y;
   logic [ADDR_W-1:0] addr;
   logic              in_range;
   rd_tag_t [2:0]     tag;
   assign q_ready = Reset && !disp_active;
   assign sel_q   = !disp_active && q_req;
   assign issue   = disp_active || q_req;
   assign x       = disp_active ? DrawX : q_x;
   assign y       = disp_active ? DrawY : q_y;
   bg_addr_calc u_calc (
      .x        (x),
      .y        (y),
      .addr     (addr),
      .in_range (in_range)
   );
   // tag[1] lines up with rom_data; tag[2] qualifies the registered outputs
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         rom_addr   <= '0;
         tag        <= '0;
         disp_index <= '0;
         q_rdata    <= '0;
      end else begin
         if (issue && in_range) rom_addr <= addr;
         tag <= {tag[1:0], rd_tag_t'{valid: issue, owner: sel_q ? OWN_QUERY : OWN_DISP,
                                     zero: !(issue && in_range)}};
         if (tag[1].valid && tag[1].owner == OWN_DISP) disp_index <= tag[1].zero ? '0 : rom_data;
         if (tag[1].valid && tag[1].owner == OWN_QUERY) q_rdata <= tag[1].zero ? '0 : rom_data;
      end
   end
   assign disp_valid = tag[2].valid && tag[2].owner == OWN_DISP;
   assign q_rvalid   = tag[2].valid && tag[2].owner == OWN_QUERY;
   assign q_err      = q_rvalid && tag[2].zero;
endmodule

// File: tb/tb_background_rom_arbiter.sv
// tb_background_rom_arbiter: random + directed check against a cycle-scheduled result model
module tb_background_rom_arbiter;
   logic        Clk = 0;
   logic        Reset = 0;
   logic [9:0]  DrawX = 0, DrawY = 0, q_x = 0, q_y = 0;
   logic        disp_active = 0, q_req = 0;
   logic        disp_valid, q_ready, q_rvalid, q_err;
   logic [3:0]  disp_index, q_rdata, rom_data;
   logic [18:0] rom_addr;
   int pass_n = 0, total_n = 0, cyc = 0, dv_cnt = 0;
   bit          m_on = 0, acc;
   bit          ev_v[8], ev_q[8], ev_z[8];
   logic [3:0]  ev_d[8];
   logic        m_dv = 0, m_qv = 0, m_qe = 0;
   logic [3:0]  m_di = 0, m_qd = 0;
   logic [18:0] m_addr = 0, saved_addr;
   int          mk, mj, mx, my;
   bit          m_inr;

   background_rom_arbiter dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .disp_active(disp_active),
      .disp_valid(disp_valid), .disp_index(disp_index), .q_req(q_req), .q_x(q_x), .q_y(q_y),
      .q_ready(q_ready), .q_rvalid(q_rvalid), .q_rdata(q_rdata), .q_err(q_err),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   initial forever #5 Clk = ~Clk;

   function automatic logic [3:0] rom_f(input logic [18:0] a);
      return a[3:0] ^ a[8:5] ^ a[15:12] ^ {1'b0, a[18:16]};
   endfunction

   always @(posedge Clk) rom_data <= rom_f(rom_addr);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_n++;
      if (got === exp) pass_n++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
   endtask

   // Model: each accepted slot schedules its result two edges later; reset wipes the schedule
   always @(posedge Clk) begin
      mk = cyc % 8;
      if (!Reset) begin
         for (int i = 0; i < 8; i++) ev_v[i] = 0;
         {m_dv, m_qv, m_qe, m_di, m_qd, m_addr} = '0;
         m_on = 1;
      end else begin
         m_dv = ev_v[mk] && !ev_q[mk];
         m_qv = ev_v[mk] && ev_q[mk];
         m_qe = m_qv && ev_z[mk];
         if (m_dv) m_di = ev_d[mk];
         if (m_qv) m_qd = ev_d[mk];
         ev_v[mk] = 0;
         if (disp_active || q_req) begin
            mx = disp_active ? int'(DrawX) : int'(q_x);
            my = disp_active ? int'(DrawY) : int'(q_y);
            m_inr = mx < 640 && my < 480;
            mj = (cyc + 2) % 8;
            ev_v[mj] = 1;
            ev_q[mj] = !disp_active;
            ev_z[mj] = !m_inr;
            ev_d[mj] = m_inr ? rom_f(19'(my * 640 + mx)) : 4'd0;
            if (m_inr) m_addr = 19'(my * 640 + mx);
         end
      end
      cyc++;
   end

   always @(negedge Clk) begin
      if (disp_valid === 1'b1) dv_cnt++;
      if (m_on) begin
         chk("disp_valid", 32'(disp_valid), 32'(m_dv));
         chk("disp_index", 32'(disp_index), 32'(m_di));
         chk("q_rvalid", 32'(q_rvalid), 32'(m_qv));
         chk("q_rdata", 32'(q_rdata), 32'(m_qd));
         chk("q_err", 32'(q_err), 32'(m_qe));
         chk("rom_addr", 32'(rom_addr), 32'(m_addr));
         chk("q_ready", 32'(q_ready), 32'(Reset && !disp_active));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      repeat (3) step();
      chk("rst_rom_addr", 32'(rom_addr), 0);
      chk("rst_disp_valid", 32'(disp_valid), 0);
      chk("rst_q_rvalid", 32'(q_rvalid), 0);
      chk("rst_q_ready", 32'(q_ready), 0);
      Reset = 1;
      step();
      // display corners
      disp_active = 1; DrawX = 0; DrawY = 0;
      step();
      chk("corner0_addr", 32'(rom_addr), 0);
      DrawX = 639; DrawY = 479;
      step();
      chk("corner1_addr", 32'(rom_addr), 307199);
      disp_active = 0;
      step();
      chk("corner0_valid", 32'(disp_valid), 1);
      chk("corner0_index", 32'(disp_index), 0);
      step();
      chk("corner1_valid", 32'(disp_valid), 1);
      chk("corner1_index", 32'(disp_index), 14);
      step();
      chk("corner_idle", 32'(disp_valid), 0);
      // single query
      q_req = 1; q_x = 10; q_y = 2;
      #1 chk("q_ready_idle", 32'(q_ready), 1);
      step();
      q_req = 0;
      chk("query_addr", 32'(rom_addr), 1290);
      step();
      step();
      chk("query_rvalid", 32'(q_rvalid), 1);
      chk("query_err", 32'(q_err), 0);
      chk("query_rdata", 32'(q_rdata), 2);
      step(); step();
      // contention: display wins for five cycles, query goes on the sixth
      dv_cnt = 0;
      q_req = 1; q_x = 100; q_y = 50; disp_active = 1;
      for (int i = 0; i < 5; i++) begin
         DrawX = 10'(i * 7); DrawY = 10'(i);
         #1 chk("contend_ready", 32'(q_ready), 0);
         step();
      end
      disp_active = 0;
      #1 chk("contend_accept", 32'(q_ready), 1);
      step();
      q_req = 0;
      repeat (4) step();
      chk("contend_disp_pulses", 32'(dv_cnt), 5);
      // out-of-range query then display
      saved_addr = rom_addr;
      q_req = 1; q_x = 640; q_y = 0;
      step();
      q_req = 0; disp_active = 1; DrawX = 5; DrawY = 480;
      step();
      disp_active = 0;
      chk("oor_addr_hold", 32'(rom_addr), 32'(saved_addr));
      step();
      chk("oor_q_rvalid", 32'(q_rvalid), 1);
      chk("oor_q_err", 32'(q_err), 1);
      chk("oor_q_rdata", 32'(q_rdata), 0);
      step();
      chk("oor_disp_valid", 32'(disp_valid), 1);
      chk("oor_disp_index", 32'(disp_index), 0);
      chk("oor_addr_hold2", 32'(rom_addr), 32'(saved_addr));
      // reset with three queries in flight
      q_req = 1;
      for (int i = 1; i <= 3; i++) begin
         q_x = 10'(i * 20); q_y = 10'(i);
         step();
      end
      q_req = 0; Reset = 0;
      step();
      chk("mid_rst_addr", 32'(rom_addr), 0);
      chk("mid_rst_q_rvalid", 32'(q_rvalid), 0);
      chk("mid_rst_q_rdata", 32'(q_rdata), 0);
      chk("mid_rst_q_err", 32'(q_err), 0);
      chk("mid_rst_disp_index", 32'(disp_index), 0);
      Reset = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_no_pulse", 32'(q_rvalid), 0);
      end
      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         Reset = ($urandom_range(0, 199) != 0);
         disp_active = 1'($urandom_range(0, 1));
         DrawX = 10'($urandom_range(0, 700));
         DrawY = 10'($urandom_range(0, 520));
         if (!q_req && $urandom_range(0, 2) == 0) begin
            q_req = 1;
            q_x = 10'($urandom_range(0, 700));
            q_y = 10'($urandom_range(0, 520));
         end
         acc = q_req && Reset && !disp_active;
         step();
         if (acc) q_req = 0;
      end
      Reset = 1; disp_active = 0; q_req = 0;
      repeat (4) step();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
